// File: rtl/occ_mem_arbiter.sv
// Round-robin arbiter that lets N_CH search engines share one Occ memory read port.
// Optional read watchdog is built only when OCC_TIMEOUT_EN is defined.
module occ_mem_arbiter #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH*ADDR_W-1:0] ch_addr,
  output logic [N_CH-1:0]        ch_gnt,
  output logic [N_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]      ch_rdata,
  output logic                   ch_rerr,
  output logic                   ce_rom_Occ_o,
  output logic [ADDR_W-1:0]      addr_rom_Occ_o,
  input  logic [DATA_W-1:0]      data_Occ_i,
  input  logic                   data_valid_i
);

  localparam int unsigned IdW = $clog2(N_CH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [N_CH-1:0]     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                ce_q, ce_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                found;
  logic [IdW-1:0]      sel;
  logic [IdW-1:0]      idx;

`ifdef OCC_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       wd_expired;
  assign wd_expired = (wd_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Search starts at the round-robin pointer and wraps modulo N_CH.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    idx   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      idx = IdW'((int'(ptr_q) + i) % int'(N_CH));
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    ce_d     = ce_q;
    addr_d   = addr_q;
`ifdef OCC_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          id_d       = sel;
          addr_d     = ch_addr[sel*ADDR_W +: ADDR_W];
          gnt_d[sel] = 1'b1;
          ce_d       = 1'b1;
          ptr_d      = (sel == IdW'(N_CH - 1)) ? '0 : sel + 1'b1;
          state_d    = StWait;
`ifdef OCC_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end
      StWait: begin
        // A valid strobe in the expiry cycle still wins over the watchdog.
        if (data_valid_i) begin
          rdata_d        = data_Occ_i;
          rerr_d         = 1'b0;
          rvalid_d[id_q] = 1'b1;
          ce_d           = 1'b0;
          state_d        = StIdle;
        end
`ifdef OCC_TIMEOUT_EN
        else if (wd_expired) begin
          rdata_d        = '0;
          rerr_d         = 1'b1;
          rvalid_d[id_q] = 1'b1;
          ce_d           = 1'b0;
          state_d        = StIdle;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      ce_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      ce_q     <= ce_d;
      addr_q   <= addr_d;
    end
  end

  assign ch_gnt         = gnt_q;
  assign ch_rvalid      = rvalid_q;
  assign ch_rdata       = rdata_q;
  assign ch_rerr        = rerr_q;
  assign ce_rom_Occ_o   = ce_q;
  assign addr_rom_Occ_o = addr_q;

endmodule

// File: doc/occ_mem_arbiter.md
# occ_mem_arbiter

Parametrised N-channel arbiter that shares one Occ memory read port among several backward-search engines. It replaces the single-requester, direct-wired `rom_Occ` connection inside the accelerator. The block issues one Occ read at a time and holds the chip enable and address until the memory's `valid` strobe. It then returns the registered data to the granted channel. Channels are served round-robin, and an optional watchdog aborts reads the memory never completes.

## Interface

Parameters:
- `N_CH`, 4, number of requesting channels (2..8)
- `ADDR_W`, 8, Occ address width
- `DATA_W`, 32, Occ data width
- `TIMEOUT`, 16, watchdog limit in cycles (used only with `OCC_TIMEOUT_EN`; 2..255)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ch_req`  in  N_CH  per-channel read request; held high until the matching `ch_gnt`
- `ch_addr`  in  N_CH*ADDR_W  flattened addresses; channel i at bits [i*ADDR_W +: ADDR_W]
- `ch_gnt`  out  N_CH  one-hot, one-cycle accept pulse
- `ch_rvalid`  out  N_CH  one-hot, one-cycle response pulse
- `ch_rdata`  out  DATA_W  shared response data; meaningful while any `ch_rvalid` bit is high
- `ch_rerr`  out  1  response error flag; qualified by `ch_rvalid`
- `ce_rom_Occ_o`  out  1  memory chip enable
- `addr_rom_Occ_o`  out  ADDR_W  memory address
- `data_Occ_i`  in  DATA_W  memory data
- `data_valid_i`  in  1  memory data valid; sampled only in WAIT

## Operation

- FSM has two states, IDLE and WAIT. All outputs are registered.
- Reset values:
  - state = IDLE
  - `ch_gnt`, `ch_rvalid` = 0
  - `ch_rdata` = 0, `ch_rerr` = 0
  - `ce_rom_Occ_o` = 0, `addr_rom_Occ_o` = 0
  - round-robin pointer = 0, so channel 0 has highest priority
  - granted-id register = 0, watchdog counter = 0
- IDLE, with any `ch_req` bit high:
  - select the first requesting channel searching pointer, pointer+1, … (mod `N_CH`)
  - latch the channel id and its address
  - pulse `ch_gnt[id]`; set `ce_rom_Occ_o` = 1 and drive `addr_rom_Occ_o` = the latched address
  - pointer ← (id+1) mod `N_CH`; go to WAIT
- IDLE, no request: outputs hold their inactive values.
- WAIT, `data_valid_i` = 1:
  - `ch_rdata` ← `data_Occ_i`; `ch_rerr` ← 0; pulse `ch_rvalid[id]`
  - `ce_rom_Occ_o` ← 0; go to IDLE
- WAIT, `data_valid_i` = 0: hold `ce_rom_Occ_o` and `addr_rom_Occ_o` unchanged; no request is accepted.
- `data_valid_i` in IDLE is ignored.
- `ch_rdata` holds its last value between responses.
- A requester must drop `ch_req` in the cycle `ch_gnt` is seen. If `ch_req` is still high at the next IDLE sample, it is a new request.
- If `ch_req` drops before a grant, the request is withdrawn without any response.
- `ch_addr` of a requester is sampled only in the grant cycle.
- Only one read is outstanding at a time. No response reordering.
- Async reset asserted mid-WAIT:
  - the read is abandoned immediately and no `ch_rvalid` is issued
  - the memory sees `ce_rom_Occ_o` fall asynchronously

## Timing

- Request sampled at edge k in IDLE: `ch_gnt`, `ce_rom_Occ_o` and `addr_rom_Occ_o` are valid after edge k.
- `data_valid_i` high at edge k+1 (zero-wait memory): `ch_rvalid` and `ch_rdata` are valid after edge k+1; next grant at edge k+2 at the earliest.
- Minimum latency is 2 cycles from request to response. Peak throughput is one read per 2 cycles.
- With W memory wait cycles, latency is 2+W.
- Fairness: with all channels requesting continuously, each channel is granted once in every `N_CH` grants.

## Configuration

- `OCC_TIMEOUT_EN` defined:
  - the watchdog counter clears on entry to WAIT and increments each WAIT cycle
  - if `data_valid_i` is still 0 when the counter reaches `TIMEOUT`, the read completes with `ch_rvalid[id]` pulsed, `ch_rerr` = 1 and `ch_rdata` = 0
  - `ce_rom_Occ_o` drops and the FSM returns to IDLE
  - `data_valid_i` arriving in the same cycle as the timeout wins: normal data, `ch_rerr` = 0
- `OCC_TIMEOUT_EN` undefined: no counter is built, WAIT persists indefinitely, and `ch_rerr` is constant 0.

## Test plan

- Reset, then single request: `ch_req` = 4'b0100 with channel 2 addr 8'h3C, and memory valid 1 cycle after ce. Expect `ch_gnt` = 4'b0100 and `addr_rom_Occ_o` = 8'h3C in the same cycle; `ch_rvalid` = 4'b0100 with `ch_rdata` = memory word 0x3C one cycle later.
- All four channels requesting continuously, zero-wait memory: grant order 0,1,2,3,0 and one `ch_rvalid` every 2 cycles.
- Memory delays valid by 5 cycles: ce and addr are held stable for 6 cycles, no `ch_gnt` is issued during WAIT, and the response arrives 7 cycles after the request.
- Channel 1 raises `ch_req` while channel 0 is in WAIT, then drops it before the grant: no `ch_gnt[1]` and no `ch_rvalid[1]`.
- `rst_n` low for 1 cycle during WAIT: all outputs are 0 immediately, no response follows, and the next request gives channel 0 priority.
- With `OCC_TIMEOUT_EN` and `TIMEOUT` = 16, memory never valid: `ch_rvalid` pulses with `ch_rerr` = 1 and `ch_rdata` = 0 exactly 16 cycles after entering WAIT. Without the macro, no response is ever issued.
